// File: rtl/mul_mux_pipe.sv
// mul_mux_pipe: N-way, WIDTH-bit registered multiplexer built around a single multiplier.
// The selected channel is moved to the top channel slot by multiplying the packed inputs
// by a one-hot power of two. The top slot is then taken as the output.
// Two-stage elastic pipeline with valid/ready handshakes on the input and the output.
// Optional feature: define MUL_MUX_SEL_CHECK_EN to add the sticky sel_err out-of-range flag.
module mul_mux_pipe #(
    parameter  int WIDTH      = 8,
    parameter  int NUM_INPUTS = 4,
    localparam int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef MUL_MUX_SEL_CHECK_EN
    ,
    output logic                        sel_err
`endif
);

    localparam int DW        = NUM_INPUTS * WIDTH;
    localparam int SHIFT_TOP = (NUM_INPUTS - 1) * WIDTH;
    localparam int SEL_SPAN  = 1 << SEL_W;

    // Table of legal select codes. Bit k is set when channel k exists.
    // This covers non-power-of-two channel counts without a constant compare.
    localparam logic [SEL_SPAN-1:0] SEL_OK = {SEL_SPAN{1'b1}} >> (SEL_SPAN - NUM_INPUTS);
    localparam logic [DW-1:0]       Y_ONE  = DW'(1);

    // Stage 1 holds the operands and their valid bit.
    logic [DW-1:0]    x;
    logic [DW-1:0]    y;
    logic [SEL_W-1:0] s;
    logic             s1v;

    logic             sel_ok;
    logic [DW-1:0]    y_next;
    logic             in_xfer;
    logic             s2_adv;
    logic [WIDTH-1:0] s2_data;

    // Decode the select into a one-hot multiplier. Out-of-range selects give a zero multiplier.
    always_comb begin
        // NOTE: assign each always_comb output a default first so that no path can infer a latch.
        sel_ok = SEL_OK[in_sel];
        y_next = '0;
        if (sel_ok) begin
            y_next = Y_ONE << (SHIFT_TOP - int'(in_sel) * WIDTH);
        end
    end

    // Stage 2 loads when stage 1 holds an item and the output slot is free or draining.
    // in_ready depends on out_ready but never on in_valid.
    assign s2_adv   = s1v && (!out_valid || out_ready);
    assign in_ready = !s1v || s2_adv;
    assign in_xfer  = in_valid && in_ready;

    // Only the low DW bits of the full 2*DW-bit product can reach the top channel slot.
    // Truncate the product to DW bits and keep that slot.
    assign s2_data = WIDTH'((x * y) >> SHIFT_TOP);

    // Stage 1 register: capture operands on an input transfer. Clear the valid bit when the item moves on.
    // The reset is asynchronous. Synchronising its release is left to the reset source.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the datapath registers are reset along with the valid bits, so a mid-stream reset leaves no stale operand behind.
        if (reset) begin
            x   <= '0;
            y   <= '0;
            s   <= '0;
            s1v <= 1'b0;
        end else if (in_xfer) begin
            // NOTE: non-blocking assignments let both stages sample their pre-edge values on the same edge.
            x   <= in_data;
            y   <= y_next;
            s   <= in_sel;
            s1v <= 1'b1;
        end else if (s2_adv) begin
            s1v <= 1'b0;
        end
    end

    // Stage 2 / output register: load the product slice on advance. Drop the valid bit when drained with nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_data  <= s2_data;
            out_sel   <= s;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUL_MUX_SEL_CHECK_EN
    // Sticky flag: set when an out-of-range select is accepted. Only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (in_xfer && !sel_ok) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_mux_pipe.sv
// tb_mul_mux_pipe: directed bench for mul_mux_pipe.
// It uses three instances: WIDTH=8/N=4, WIDTH=8/N=3 and WIDTH=16/N=2.
// With MUL_MUX_SEL_CHECK_EN defined, the sel_err flag is connected and checked as well.
module tb_mul_mux_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // u4: WIDTH=8, NUM_INPUTS=4
    logic [31:0] d4;
    logic [1:0]  sel4, os4;
    logic [7:0]  od4;
    logic        iv4, ir4, ov4, or4;
    // u3: WIDTH=8, NUM_INPUTS=3
    logic [23:0] d3;
    logic [1:0]  sel3, os3;
    logic [7:0]  od3;
    logic        iv3, ir3, ov3, or3;
    // u2: WIDTH=16, NUM_INPUTS=2
    logic [31:0] d2;
    logic [0:0]  sel2, os2;
    logic [15:0] od2;
    logic        iv2, ir2, ov2, or2;
`ifdef MUL_MUX_SEL_CHECK_EN
    logic        err4, err3, err2;
`endif

    mul_mux_pipe #(.WIDTH(8), .NUM_INPUTS(4)) u4 (
        .clk(clk), .reset(reset), .in_data(d4), .in_sel(sel4), .in_valid(iv4), .in_ready(ir4),
        .out_data(od4), .out_sel(os4), .out_valid(ov4), .out_ready(or4)
`ifdef MUL_MUX_SEL_CHECK_EN
        , .sel_err(err4)
`endif
    );

    mul_mux_pipe #(.WIDTH(8), .NUM_INPUTS(3)) u3 (
        .clk(clk), .reset(reset), .in_data(d3), .in_sel(sel3), .in_valid(iv3), .in_ready(ir3),
        .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_ready(or3)
`ifdef MUL_MUX_SEL_CHECK_EN
        , .sel_err(err3)
`endif
    );

    mul_mux_pipe #(.WIDTH(16), .NUM_INPUTS(2)) u2 (
        .clk(clk), .reset(reset), .in_data(d2), .in_sel(sel2), .in_valid(iv2), .in_ready(ir2),
        .out_data(od2), .out_sel(os2), .out_valid(ov2), .out_ready(or2)
`ifdef MUL_MUX_SEL_CHECK_EN
        , .sel_err(err2)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock. Both sampling and driving happen 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp1 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] q_data [$];
    logic [1:0] q_sel [$];
    int         sent;
    int         got;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        d4 = '0; sel4 = '0; iv4 = 1'b0; or4 = 1'b1;
        d3 = '0; sel3 = '0; iv3 = 1'b0; or3 = 1'b1;
        d2 = '0; sel2 = '0; iv2 = 1'b0; or2 = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Reset state
        check("rst out_valid", ov4, 0);
        check("rst out_data", od4, 0);
        check("rst out_sel", os4, 0);
        check("rst u3 out_valid", ov3, 0);
        check("rst u2 out_valid", ov2, 0);
`ifdef MUL_MUX_SEL_CHECK_EN
        check("rst sel_err", err3, 0);
`endif
        tick();
        check("rst in_ready", ir4, 1);

        // 1: back-to-back selects 0..3 with out_ready held high. The latency is 2 cycles.
        d4 = 32'hDDCCBBAA;
        for (int i = 0; i < 7; i++) begin
            iv4  = (i < 4);
            sel4 = 2'(i);
            tick();
            if (i >= 1 && i <= 4) begin
                check("t1 out_valid", ov4, 1);
                check("t1 out_data", od4, exp1[i-1]);
                check("t1 out_sel", os4, i - 1);
            end else begin
                check("t1 idle", ov4, 0);
            end
        end

        // 2: output stalled. Two items are accepted, then in_ready drops. Release drains in order.
        or4 = 1'b0; iv4 = 1'b1; sel4 = 2'd3;
        #1 check("t2 accept 1", ir4, 1);
        tick();
        sel4 = 2'd2;
        #1 check("t2 accept 2", ir4, 1);
        tick();
        sel4 = 2'd1;
        #1 check("t2 full in_ready", ir4, 0);
        check("t2 first valid", ov4, 1);
        check("t2 first data", od4, 8'hDD);
        check("t2 first sel", os4, 3);
        tick();
        tick();
        check("t2 hold data", od4, 8'hDD);
        check("t2 hold in_ready", ir4, 0);
        or4 = 1'b1;
        #1 check("t2 release in_ready", ir4, 1);
        tick();
        iv4 = 1'b0;
        check("t2 second data", od4, 8'hCC);
        check("t2 second sel", os4, 2);
        tick();
        check("t2 third data", od4, 8'hBB);
        check("t2 third sel", os4, 1);
        tick();
        check("t2 drained", ov4, 0);

        // 3: N=3 with an out-of-range select. The output slice is zero and out_sel carries the raw select.
        d3 = 24'h332211; iv3 = 1'b1; sel3 = 2'd3;
        tick();
`ifdef MUL_MUX_SEL_CHECK_EN
        check("t3 sel_err set", err3, 1);
`endif
        sel3 = 2'd2;
        tick();
        iv3 = 1'b0;
        check("t3 oor valid", ov3, 1);
        check("t3 oor data", od3, 8'h00);
        check("t3 oor sel", os3, 3);
        tick();
        check("t3 valid data", od3, 8'h33);
        check("t3 valid sel", os3, 2);
`ifdef MUL_MUX_SEL_CHECK_EN
        check("t3 sel_err sticky", err3, 1);
        check("t3 u4 sel_err", err4, 0);
`endif

        // 4: reset while both stages are full. The valid bits clear without a clock edge.
        d4 = 32'hDDCCBBAA; or4 = 1'b0; iv4 = 1'b1; sel4 = 2'd0;
        tick();
        sel4 = 2'd1;
        tick();
        iv4 = 1'b0;
        check("t4 full data", od4, 8'hAA);
        #2 reset = 1'b1;
        #1 check("t4 async out_valid", ov4, 0);
        check("t4 async out_data", od4, 0);
        check("t4 async out_sel", os4, 0);
        #2 reset = 1'b0;
        tick();
        check("t4 in_ready after release", ir4, 1);
        check("t4 out_valid after release", ov4, 0);
`ifdef MUL_MUX_SEL_CHECK_EN
        check("t4 sel_err cleared", err3, 0);
`endif

        // 5: steady input with out_ready toggling. A scoreboard checks order, duplicates and gaps.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 24; c++) begin
            or4  = (c % 2 == 0);
            iv4  = 1'b1;
            sel4 = 2'((sent * 3) % 4);
            d4   = {8'(4*sent+3), 8'(4*sent+2), 8'(4*sent+1), 8'(4*sent)} ^ 32'h5A5A5A5A;
            #1;
            if (ov4 && or4) begin
                if (q_data.size() == 0) begin
                    check("t5 unexpected output", 1, 0);
                end else begin
                    check("t5 data", od4, q_data.pop_front());
                    check("t5 sel", os4, q_sel.pop_front());
                    got++;
                end
            end
            if (iv4 && ir4) begin
                q_data.push_back(d4[sel4*8 +: 8]);
                q_sel.push_back(sel4);
                sent++;
            end
            tick();
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (ov4) begin
                if (q_data.size() == 0) begin
                    check("t5 extra output", 1, 0);
                end else begin
                    check("t5 drain data", od4, q_data.pop_front());
                    check("t5 drain sel", os4, q_sel.pop_front());
                    got++;
                end
            end
            tick();
        end
        check("t5 left in scoreboard", q_data.size(), 0);
        check("t5 delivered count", got, sent);

        // 6: WIDTH=16, N=2
        d2 = 32'hBEEF_1234; iv2 = 1'b1; sel2 = 1'b1;
        tick();
        sel2 = 1'b0;
        tick();
        iv2 = 1'b0;
        check("t6 valid", ov2, 1);
        check("t6 data sel1", od2, 16'hBEEF);
        check("t6 sel1", os2, 1);
        tick();
        check("t6 data sel0", od2, 16'h1234);
        check("t6 sel0", os2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
